// File: rtl/vanilla_int_scoreboard.sv
// vanilla_int_scoreboard
// ID-stage integer register-file scoreboard. One pending bit per register marks a
// destination owned by an in-flight long-latency op (remote load, AMO, idiv).
// The instruction sitting in ID is checked against these bits for RAW/WAW hazards.
// Writeback clears are bypassed into the hazard check so a retiring result wakes its
// consumer with no bubble. New scores only become visible on the following cycle.
module vanilla_int_scoreboard #(
  parameter int  els_p            = 32,
  parameter int  num_src_port_p   = 2,
  parameter int  num_clear_port_p = 2,
  localparam int id_width_lp      = $clog2(els_p),
  localparam int cnt_width_lp     = $clog2(els_p + 1)
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic [num_src_port_p-1:0][id_width_lp-1:0] src_id_i,
  input  logic [num_src_port_p-1:0]                  op_reads_rf_i,
  input  logic [id_width_lp-1:0]                     dest_id_i,
  input  logic                                       op_writes_rf_i,
  input  logic                                       score_i,
  input  logic [id_width_lp-1:0]                     score_id_i,
  input  logic [num_clear_port_p-1:0]                clear_i,
  input  logic [num_clear_port_p-1:0][id_width_lp-1:0] clear_id_i,
  output logic                                       dependency_o,
  output logic [els_p-1:0]                           scoreboard_o,
  output logic [cnt_width_lp-1:0]                    pending_cnt_o
);

  logic [els_p-1:0]        r_scoreboard;
  logic [cnt_width_lp-1:0] r_pendingCnt;
  logic                    r_recentReset;

  logic [els_p-1:0]        w_scoreMask;
  logic [els_p-1:0]        w_clearMask;
  logic [els_p-1:0]        w_pendingBypass;
  logic [els_p-1:0]        w_sbNext;
  logic [els_p-1:0]        w_fellMask;
  logic                    w_newSet;
  logic [cnt_width_lp-1:0] w_fellCnt;
  logic [cnt_width_lp-1:0] w_cntNext;
  logic                    w_dependency;

  // One-hot of the register being newly scored; x0 can never become pending.
  always_comb begin
    w_scoreMask = '0;
    if (score_i && (score_id_i != '0)) begin
      w_scoreMask[score_id_i] = 1'b1;
    end
  end

  // Union of all registers retiring this cycle across every writeback port.
  always_comb begin
    w_clearMask = '0;
    for (int p = 0; p < num_clear_port_p; p++) begin
      if (clear_i[p]) begin
        w_clearMask[clear_id_i[p]] = 1'b1;
      end
    end
    w_clearMask[0] = 1'b0;
  end

  // Pending view with this cycle's clears already removed, used for the hazard check.
  assign w_pendingBypass = r_scoreboard & ~w_clearMask;

  // Score wins over a same-cycle clear, so the bit is simply OR-ed back in.
  assign w_sbNext = w_scoreMask | w_pendingBypass;

  // RAW on any read port or WAW on the destination, both against the bypassed view.
  always_comb begin
    w_dependency = 1'b0;
    for (int p = 0; p < num_src_port_p; p++) begin
      if (op_reads_rf_i[p] && (src_id_i[p] != '0) && w_pendingBypass[src_id_i[p]]) begin
        w_dependency = 1'b1;
      end
    end
    if (op_writes_rf_i && (dest_id_i != '0) && w_pendingBypass[dest_id_i]) begin
      w_dependency = 1'b1;
    end
  end

  // Count update: +1 for a bit going 0->1, minus every bit going 1->0.
  always_comb begin
    w_newSet   = |(w_scoreMask & ~r_scoreboard);
    w_fellMask = r_scoreboard & ~w_sbNext;
    w_fellCnt  = '0;
    for (int i = 0; i < els_p; i++) begin
      w_fellCnt = w_fellCnt + cnt_width_lp'(w_fellMask[i]);
    end
    w_cntNext = r_pendingCnt + cnt_width_lp'(w_newSet) - w_fellCnt;
  end

  // Pending bits and their population count, discarded wholesale on reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_scoreboard <= '0;
      r_pendingCnt <= '0;
    end else begin
      r_scoreboard <= w_sbNext;
      r_pendingCnt <= w_cntNext;
    end
  end

  // Remembers the reset cycle so late clears for discarded ids are tolerated once.
  always_ff @(posedge clk_i) begin
    r_recentReset <= reset_i;
  end

  assign dependency_o  = w_dependency;
  assign scoreboard_o  = r_scoreboard;
  assign pending_cnt_o = r_pendingCnt;

  // The counter is a cached popcount and must never drift from the bit vector.
  assert property (@(posedge clk_i) disable iff (reset_i)
    r_pendingCnt == cnt_width_lp'($countones(r_scoreboard)))
    else $error("scoreboard: pending count disagrees with pending bits");

  // Scoring an already-pending register means a WAW hazard slipped past the stall.
  assert property (@(posedge clk_i) disable iff (reset_i)
    (score_i && (score_id_i != '0)) |-> (!r_scoreboard[score_id_i] || w_clearMask[score_id_i]))
    else $error("scoreboard: score to already-pending register");

  for (genvar p = 0; p < num_clear_port_p; p++) begin : g_staleClear
    // A clear for a register that is not pending is a lost or duplicated writeback.
    assert property (@(posedge clk_i) disable iff (reset_i || r_recentReset)
      clear_i[p] |-> r_scoreboard[clear_id_i[p]])
      else $error("scoreboard: stale clear on port %0d", p);
  end

  for (genvar p = 0; p < num_clear_port_p; p++) begin : g_dupClearA
    for (genvar q = p + 1; q < num_clear_port_p; q++) begin : g_dupClearB
      // Two writeback ports must never retire the same register together.
      assert property (@(posedge clk_i) disable iff (reset_i)
        !(clear_i[p] && clear_i[q] && (clear_id_i[p] == clear_id_i[q]) && (clear_id_i[p] != '0)))
        else $error("scoreboard: ports %0d and %0d clear the same register", p, q);
    end
  end

endmodule
